// File: rtl/ps2_key_ctrl.sv
// Pops set-2 scan codes from the keyboard FIFO, decodes the E0/F0 prefixes and tracks
// the held key plus a count of distinct presses. All outputs are registered.
module ps2_key_ctrl #(
  parameter int unsigned COUNT_W    = 8,
  parameter logic [7:0]  EXT_CODE   = 8'hE0,
  parameter logic [7:0]  BREAK_CODE = 8'hF0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         ps2_data,
  input  logic               ps2_ready,
  output logic               ps2_nextdata_n,
  output logic [7:0]         key_code,
  output logic               key_ext,
  output logic               key_valid,
  output logic [COUNT_W-1:0] key_count,
  output logic               make_pulse,
  output logic               break_pulse
);

  typedef enum logic [1:0] {StIdle, StPop, StGap} state_e;

  state_e state_q, state_d;

  logic [7:0]         byte_q, byte_d;
  logic               ext_pend_q, ext_pend_d;
  logic               brk_pend_q, brk_pend_d;
  logic [7:0]         code_q, code_d;
  logic               ext_q, ext_d;
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               make_q, make_d;
  logic               brk_q, brk_d;
  logic               nextdata_n_q, nextdata_n_d;
  logic               same_key;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (ps2_ready) state_d = StPop;
      StPop:   state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte matches the tracked key including its extended flag
  assign same_key = valid_q && (byte_q == code_q) && (ext_pend_q == ext_q);

  // Output / datapath next-state logic
  always_comb begin
    byte_d       = byte_q;
    ext_pend_d   = ext_pend_q;
    brk_pend_d   = brk_pend_q;
    code_d       = code_q;
    ext_d        = ext_q;
    valid_d      = valid_q;
    count_d      = count_q;
    make_d       = 1'b0;
    brk_d        = 1'b0;
    nextdata_n_d = (state_d != StPop);

    if (state_q == StIdle && ps2_ready) begin
      byte_d = ps2_data;
    end

    if (state_q == StPop) begin
      if (byte_q == EXT_CODE) begin
        ext_pend_d = 1'b1;
      end else if (byte_q == BREAK_CODE) begin
        brk_pend_d = 1'b1;
      end else begin
        if (brk_pend_q) begin
          brk_d = 1'b1;
          // Releasing a key other than the tracked one leaves key_valid alone
          if (same_key) valid_d = 1'b0;
        end else if (!same_key) begin
          code_d  = byte_q;
          ext_d   = ext_pend_q;
          valid_d = 1'b1;
          count_d = count_q + COUNT_W'(1);
          make_d  = 1'b1;
        end
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q       <= 8'h00;
      ext_pend_q   <= 1'b0;
      brk_pend_q   <= 1'b0;
      code_q       <= 8'h00;
      ext_q        <= 1'b0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      make_q       <= 1'b0;
      brk_q        <= 1'b0;
      nextdata_n_q <= 1'b1;
    end else begin
      byte_q       <= byte_d;
      ext_pend_q   <= ext_pend_d;
      brk_pend_q   <= brk_pend_d;
      code_q       <= code_d;
      ext_q        <= ext_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      make_q       <= make_d;
      brk_q        <= brk_d;
      nextdata_n_q <= nextdata_n_d;
    end
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign key_code       = code_q;
  assign key_ext        = ext_q;
  assign key_valid      = valid_q;
  assign key_count      = count_q;
  assign make_pulse     = make_q;
  assign break_pulse    = brk_q;

endmodule
